imem_loader: RTL
================

Name: imem_loader

Overview:
- Boot-time program loader: writer side of the instruction memory.
- Accepts a little-endian byte stream on a valid/ready interface, assembles 32-bit instructions and drives a single-cycle write port into instruction memory at word-aligned byte addresses.
- Holds the core in reset while a load is in progress, so the core fetches only from a fully written image.

Parameters:
- DEPTH, 32, instruction memory size in 32-bit words; maximum accepted word count.
- BASE_ADDR, 32'h0000_0000, byte address of the first written word; must be 4-byte aligned.
- CW, $clog2(DEPTH)+1, width of the word counter.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle request to begin a load; honoured only in IDLE or ERR.
- in_valid  input  1  byte on in_data is valid.
- in_data  input  8  stream byte.
- in_ready  output  1  loader can accept a byte; a byte transfers when in_valid and in_ready are both high.
- mem_we  output  1  instruction memory write enable, one-cycle pulse per word.
- mem_addr  output  32  byte address of the write; always a multiple of 4.
- mem_wdata  output  32  instruction word.
- busy  output  1  high in LEN, DATA and WRITE.
- done  output  1  one-cycle pulse on successful completion.
- err  output  1  sticky length error.
- cpu_hold  output  1  core reset request.
- words_loaded  output  CW  number of words written in the current or last load.

Behaviour:
- Reset: async, active-high. Sets state IDLE; in_ready, mem_we, busy, done, err and cpu_hold to 0; mem_addr, mem_wdata and words_loaded to 0; clears the byte index.
- All outputs are registered or decoded from registered state only; no combinational path from inputs to outputs.
- Stream format: 4 length bytes giving N (LSB first), then N words of 4 bytes each, LSB first. Byte k of a group lands in bits [8k+7:8k].
- IDLE:
  - in_ready=0.
  - start -> LEN: clear byte index, words_loaded and err; set cpu_hold=1 and busy=1 from the next cycle.
- LEN:
  - in_ready=1.
  - On the 4th accepted byte, evaluate N:
    - N==0 -> DONE.
    - N>DEPTH -> ERR.
    - Otherwise -> DATA.
- DATA:
  - in_ready=1.
  - On the 4th accepted byte of a word -> WRITE.
- WRITE (exactly one cycle):
  - in_ready=0; mem_we=1.
  - mem_addr = BASE_ADDR + 4*words_loaded; mem_wdata = assembled word.
  - words_loaded increments at the end of the cycle.
  - Then -> DONE if the incremented count equals N, else -> DATA.
  - Latency: 4th byte accepted at edge t; mem_we is high in cycle t+1.
- DONE (one cycle):
  - done=1, busy=0, cpu_hold=0, in_ready=0.
  - Then -> IDLE.
- ERR:
  - err=1, cpu_hold stays 1, busy=0, in_ready=0; no writes are issued.
  - start -> LEN, clearing err. This is the only exit other than rst.
- start while busy: ignored; the load continues unaffected.
- in_valid gaps: any number of idle cycles between bytes is allowed. A byte presented during WRITE is not accepted and must be held by the source.
- mem_we is 0 in every state except WRITE. mem_addr and mem_wdata hold their last values otherwise.
- Words never exceed DEPTH, so mem_addr never passes BASE_ADDR + 4*(DEPTH-1).
- Reset mid-load: immediate return to IDLE; the partial word is discarded; cpu_hold drops. Words already written stay in memory, and the next start rewrites from BASE_ADDR.

Test Plan:
- Normal load: start, then bytes 02 00 00 00 13 00 00 00 93 00 10 00 with in_valid held high -> mem_we pulses twice: addr 0x0 / data 0x00000013, then addr 0x4 / data 0x00100093. Each pulse occurs one cycle after its 4th byte. done pulses for one cycle after the 2nd write; cpu_hold falls with done; words_loaded=2.
- Empty image: start, bytes 00 00 00 00 -> no mem_we. done is high in the cycle after the 4th byte; cpu_hold is 1 for exactly the load duration.
- Oversize: DEPTH=32, length bytes 21 00 00 00 (N=33) -> err=1, in_ready=0, cpu_hold=1, no writes. A following start plus a valid N=1 load clears err and writes one word.
- Backpressure/gaps: random in_valid gaps, plus a byte offered during the WRITE cycle -> that byte is accepted only after WRITE ends. The written words match the stream exactly; no byte is lost or duplicated.
- Reset mid-load: assert rst after 6 data bytes of an N=2 load -> all outputs 0 asynchronously. A new N=1 load then writes addr 0x0 with the correct data.
- Spurious start: pulse start in DATA -> no restart; words_loaded and addresses continue unchanged.

Source files
------------

// File: rtl/imem_loader.sv
// ---------------------------------------------------------------------------
// imem_loader -- boot-time program loader (instruction memory writer side)
//
// Takes a little-endian byte stream: 4 length bytes (N), then N 32-bit words
// of 4 bytes each, LSB first. Each word is written with a single-cycle
// write pulse at BASE_ADDR + 4*index. The core is held in reset while a load
// is in progress, and also while a bad length is latched in ERR.
//
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   start         request to begin a load (honoured in IDLE/ERR only)
//   in_valid      stream byte valid
//   in_data       stream byte
//   in_ready      loader accepts a byte (transfer = in_valid & in_ready)
//   mem_we        imem write enable, one pulse per word
//   mem_addr      imem byte address (word aligned)
//   mem_wdata     imem write data
//   busy          load in progress (LEN/DATA/WRITE)
//   done          one-cycle pulse on successful completion
//   err           sticky length error
//   cpu_hold      core reset request
//   words_loaded  words written in the current/last load
// ---------------------------------------------------------------------------
module imem_loader #(
    parameter int          DEPTH     = 32,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          CW        = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          in_valid,
    input  logic [7:0]    in_data,
    output logic          in_ready,
    output logic          mem_we,
    output logic [31:0]   mem_addr,
    output logic [31:0]   mem_wdata,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic          cpu_hold,
    output logic [CW-1:0] words_loaded
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_DATA,
        S_WRITE,
        S_DONE,
        S_ERR
    } state_t;

    state_t        r_state;
    state_t        w_next;

    logic [1:0]    r_idx;      // byte position within the current group
    logic [23:0]   r_buf;      // first three bytes of the current group
    logic [CW-1:0] r_len;      // N, valid once LEN has completed
    logic [31:0]   r_addr;
    logic [31:0]   r_wdata;
    logic [CW-1:0] r_wl;

    logic          w_fire;
    logic          w_last;
    logic [31:0]   w_word;
    logic [CW-1:0] w_wl_inc;
    logic          w_start_ok;

    // Outputs are pure decodes of r_state, so in_ready has no path from inputs.
    assign w_fire     = in_valid & in_ready;
    assign w_last     = w_fire & (r_idx == 2'd3);
    assign w_word     = {in_data, r_buf};
    assign w_wl_inc   = r_wl + CW'(1);
    assign w_start_ok = start & ((r_state == S_IDLE) | (r_state == S_ERR));

    assign mem_addr     = r_addr;
    assign mem_wdata    = r_wdata;
    assign words_loaded = r_wl;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next   = r_state;
        in_ready = 1'b0;
        mem_we   = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        err      = 1'b0;
        cpu_hold = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) w_next = S_LEN;
            end
            S_LEN: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                cpu_hold = 1'b1;
                if (w_last) begin
                    if (w_word == 32'd0)               w_next = S_DONE;
                    else if (w_word > 32'(DEPTH))      w_next = S_ERR;
                    else                               w_next = S_DATA;
                end
            end
            S_DATA: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                cpu_hold = 1'b1;
                if (w_last) w_next = S_WRITE;
            end
            S_WRITE: begin
                mem_we   = 1'b1;
                busy     = 1'b1;
                cpu_hold = 1'b1;
                w_next   = (w_wl_inc == r_len) ? S_DONE : S_DATA;
            end
            S_DONE: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            S_ERR: begin
                err      = 1'b1;
                cpu_hold = 1'b1;
                if (start) w_next = S_LEN;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx   <= 2'd0;
            r_buf   <= 24'd0;
            r_len   <= '0;
            r_addr  <= 32'd0;
            r_wdata <= 32'd0;
            r_wl    <= '0;
        end else begin
            if (w_start_ok) begin
                r_idx <= 2'd0;
                r_wl  <= '0;
            end

            if (w_fire) begin
                r_idx <= r_idx + 2'd1;
                case (r_idx)
                    2'd0:    r_buf[7:0]   <= in_data;
                    2'd1:    r_buf[15:8]  <= in_data;
                    2'd2:    r_buf[23:16] <= in_data;
                    default: ;
                endcase
            end

            // Only an in-range N reaches DATA, so truncation to CW bits is safe.
            if (w_last && r_state == S_LEN) begin
                r_len <= w_word[CW-1:0];
            end

            // Address and data are captured with the 4th byte so the write
            // cycle drives them straight from flops.
            if (w_last && r_state == S_DATA) begin
                r_addr  <= BASE_ADDR + 32'({r_wl, 2'b00});
                r_wdata <= w_word;
            end

            if (r_state == S_WRITE) begin
                r_wl <= w_wl_inc;
            end
        end
    end

endmodule
